fifo_umbral: RTL

FIFO_UMBRAL -- requirements
Module: fifo_umbral

---
 rtl/fifo_umbral_pkg.sv | 29 ++
 rtl/fifo_umbral_mem_fifo.sv | 27 ++
 rtl/fifo_umbral.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_umbral_pkg.sv
// Shared widths, depth and threshold field layout for the threshold FIFO.
package fifo_umbral_pkg;

   localparam int unsigned DATA_W_DEF = 6;
   localparam int unsigned ADDR_W_DEF = 3;
   localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

   // umbrales_VCFC layout: upper nibble almost-full level, lower nibble almost-empty level
   localparam int unsigned THR_W  = 8;
   localparam int unsigned LVL_W  = 4;
   localparam int unsigned AF_MSB = 7;
   localparam int unsigned AF_LSB = 4;
   localparam int unsigned AE_MSB = 3;
   localparam int unsigned AE_LSB = 0;

   typedef struct packed {
      logic [LVL_W-1:0] af;
      logic [LVL_W-1:0] ae;
   } umbral_t;

   // Split the raw threshold byte into its two levels
   function automatic umbral_t unpack_umbral(input logic [THR_W-1:0] raw);
      umbral_t u;
      u.af = raw[AF_MSB:AF_LSB];
      u.ae = raw[AE_MSB:AE_LSB];
      return u;
   endfunction

endpackage

// File: rtl/fifo_umbral_mem_fifo.sv
// Storage array for the threshold FIFO: synchronous write, address-indexed read.
module mem_fifo
   import fifo_umbral_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are not reset, stale words are unreachable after reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_umbral.sv
// Circular-buffer FIFO with programmable almost-full/almost-empty thresholds
// and a sticky overflow/underflow error flag.
module fifo_umbral
   import fifo_umbral_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [THR_W-1:0]  umbrales_VCFC,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              FIFO_empty,
   output logic              FIFO_full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              FIFO_error,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [DATA_W-1:0] rd_data;
   umbral_t           thr;
   logic              pop_ok;
   logic              push_ok;
   logic              bad_req;

   // Accept logic: a pop frees a slot, so push on full succeeds when a pop is accepted
   always_comb begin
      pop_ok  = 1'b0;
      push_ok = 1'b0;
      bad_req = 1'b0;
      pop_ok  = pop && (count != '0);
      push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
      bad_req = (push && !push_ok) || (pop && !pop_ok);
   end

   // Pointers, occupancy, read data and sticky error
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         FIFO_error <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (pop_ok) begin
            data_out <= rd_data;
            rd_ptr   <= rd_ptr + ADDR_W'(1);
         end
         if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
         else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
         if (bad_req) FIFO_error <= 1'b1;
      end
   end

   // Threshold capture, one cycle behind umbrales_VCFC
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) thr <= '0;
      else          thr <= unpack_umbral(umbrales_VCFC);
   end

   // Status flags from live occupancy; a zero almost-full level never asserts
   always_comb begin
      FIFO_empty   = 1'b0;
      FIFO_full    = 1'b0;
      almost_empty = 1'b0;
      almost_full  = 1'b0;
      FIFO_empty   = (count == '0);
      FIFO_full    = (count == CNT_W'(DEPTH));
      almost_empty = (32'(count) <= 32'(thr.ae));
      almost_full  = (thr.af != '0) && (32'(count) >= 32'(thr.af));
   end

   mem_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule
